// File: rtl/serial_arbiter.sv
// Four-requester round-robin arbiter that frames one word per grant for a serializer.
// Define SERIAL_ARB_PRIO_EN to give requester 0 absolute priority over the rotating 1..3.
module serial_arbiter #(
    parameter int WIDTH = 12,
    parameter int GAP   = 2
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] ser_data,
    output logic             ser_load,
    output logic             ser_send,
    output logic [1:0]       gnt_id,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam int CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int GAP_END = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [CW-1:0] SEND_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_END);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [1:0]       rr_ptr;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             found;
    logic [WIDTH-1:0] sel_data;

    // Rotating search from rr_ptr; in priority builds req[0] pre-empts the rotation.
    always_comb begin
        win   = rr_ptr;
        idx   = rr_ptr;
        found = 1'b0;
`ifdef SERIAL_ARB_PRIO_EN
        if (req[0]) begin
            win   = 2'd0;
            found = 1'b1;
        end
`endif
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (win)
            2'd0:    sel_data = data0;
            2'd1:    sel_data = data1;
            2'd2:    sel_data = data2;
            default: sel_data = data3;
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ser_data <= '0;
            gnt_id   <= 2'd0;
            rr_ptr   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state    <= ST_LOAD;
                        gnt_id   <= win;
                        ser_data <= sel_data;
`ifdef SERIAL_ARB_PRIO_EN
                        // Grants to requester 0 leave the 1..3 rotation untouched.
                        if (!req[0]) rr_ptr <= win + 2'd1;
`else
                        rr_ptr <= win + 2'd1;
`endif
                    end
                end
                ST_LOAD: begin
                    state <= ST_SEND;
                    cnt   <= '0;
                end
                ST_SEND: begin
                    if (cnt == SEND_LAST) begin
                        cnt   <= '0;
                        state <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Moore outputs: decoded purely from registered state and counter.
    assign ser_load  = (state == ST_LOAD);
    assign ser_send  = (state == ST_SEND);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_SEND) && (cnt == SEND_LAST);
    assign ack       = ser_load ? (4'b0001 << gnt_id) : 4'b0000;
    assign state_dbg = state;

endmodule
